// File: rtl/counter_ctrl.sv
// Run/stop/clear counter controller: steps a 0..9999 count once per TICK_DIV clocks while
// running, up or down, and pulses wrap when the count rolls over.
module counter_ctrl #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run_stop,
  input  logic        btn_clear,
  input  logic        sw_mode,
  output logic [13:0] cnt,
  output logic        run_led,
  output logic        wrap
);

  localparam logic [26:0] DivLast = 27'(TICK_DIV - 1);
  localparam logic [13:0] CntMax  = 14'd9999;

  typedef enum logic [1:0] {
    StStop,
    StRun,
    StClear
  } state_e;

  state_e      r_state;
  logic        r_btn_rs_q;
  logic        r_btn_clr_q;
  logic [26:0] r_div;
  logic [13:0] r_cnt;
  logic        r_run_led;
  logic        r_wrap;

  logic        w_rs_edge;
  logic        w_clr_edge;
  logic        w_tick;
  logic [13:0] w_cnt_next;
  logic        w_cnt_wrap;

  // Button history; cleared in reset so a button held through release gives one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_rs_q  <= 1'b0;
      r_btn_clr_q <= 1'b0;
    end else begin
      r_btn_rs_q  <= btn_run_stop;
      r_btn_clr_q <= btn_clear;
    end
  end

  // Rising-edge detection and the divider terminal-count tick.
  always_comb begin
    w_rs_edge  = btn_run_stop & ~r_btn_rs_q;
    w_clr_edge = btn_clear & ~r_btn_clr_q;
    w_tick     = (r_state == StRun) && (r_div == DivLast);
  end

  // Next count value for a tick; out-of-range values are pulled back into 0..9999.
  always_comb begin
    w_cnt_next = r_cnt;
    w_cnt_wrap = 1'b0;
    if (sw_mode) begin
      if (r_cnt == 14'd0) begin
        w_cnt_next = CntMax;
        w_cnt_wrap = 1'b1;
      end else if (r_cnt > CntMax) begin
        w_cnt_next = CntMax;
      end else begin
        w_cnt_next = r_cnt - 14'd1;
      end
    end else begin
      if (r_cnt >= CntMax) begin
        w_cnt_next = 14'd0;
        w_cnt_wrap = (r_cnt == CntMax);
      end else begin
        w_cnt_next = r_cnt + 14'd1;
      end
    end
  end

  // Control FSM with registered outputs, divider and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StStop;
      r_run_led <= 1'b0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        StStop: begin
          // Clear takes priority over run when both edges land together.
          if (w_clr_edge) begin
            r_state   <= StClear;
            r_cnt     <= '0;
            r_div     <= '0;
            r_run_led <= 1'b0;
          end else if (w_rs_edge) begin
            r_state   <= StRun;
            r_run_led <= 1'b1;
          end
        end
        StRun: begin
          r_div <= w_tick ? 27'd0 : r_div + 27'd1;
          if (w_tick) begin
            r_cnt  <= w_cnt_next;
            r_wrap <= w_cnt_wrap;
          end
          // A coinciding tick still steps the count before stopping.
          if (w_rs_edge) begin
            r_state   <= StStop;
            r_run_led <= 1'b0;
          end
        end
        StClear: begin
          r_state   <= StStop;
          r_cnt     <= '0;
          r_div     <= '0;
          r_run_led <= 1'b0;
        end
        default: begin
          r_state   <= StStop;
          r_run_led <= 1'b0;
        end
      endcase
    end
  end

  assign cnt     = r_cnt;
  assign run_led = r_run_led;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl with TICK_DIV=4: stimulus queues the expected output
// changes (cycle stamp plus values), a monitor pops one entry per observed output change.
module tb_counter_ctrl;

  localparam int unsigned TickDiv = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_run_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        sw_mode = 1'b0;
  logic [13:0] cnt;
  logic        run_led;
  logic        wrap;

  typedef struct {
    int unsigned cyc;
    logic [13:0] cnt;
    logic        wrap;
    logic        led;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;
  int unsigned t0, w0, r0;

  counter_ctrl #(
    .TICK_DIV(TickDiv)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .sw_mode     (sw_mode),
    .cnt         (cnt),
    .run_led     (run_led),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic press(input logic rs, input logic clr);
    btn_run_stop = rs;
    btn_clear    = clr;
    step();
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
  endtask

  task automatic push(input int unsigned c, input int v, input logic w, input logic l);
    ev_t e;
    e.cyc  = c;
    e.cnt  = 14'(v);
    e.wrap = w;
    e.led  = l;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Pops one expected entry for every change seen on the outputs.
  task automatic run_monitor();
    logic [13:0] p_cnt  = '0;
    logic        p_wrap = 1'b0;
    logic        p_led  = 1'b0;
    ev_t         e;
    forever begin
      @(negedge clk);
      if (mon_en && (cnt !== p_cnt || wrap !== p_wrap || run_led !== p_led)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got cyc=%0d cnt=%0d wrap=%0b led=%0b, required no change",
                   cyc, cnt, wrap, run_led);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cnt !== cnt || e.wrap !== wrap || e.led !== run_led) begin
            n_bad++;
            $display("FAIL event: got cyc=%0d cnt=%0d wrap=%0b led=%0b, required cyc=%0d cnt=%0d wrap=%0b led=%0b",
                     cyc, cnt, wrap, run_led, e.cyc, e.cnt, e.wrap, e.led);
          end
        end
        p_cnt  = cnt;
        p_wrap = wrap;
        p_led  = run_led;
      end
    end
  endtask

  initial begin
    ev_t e;
    fork
      run_monitor();
    join_none

    // Reset state
    #3 rst = 1'b0;
    step();
    step();
    chk("reset_cnt", 32'(cnt), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    chk("reset_led", 32'(run_led), 32'd0);
    mon_en = 1'b1;
    goto(4);
    rst = 1'b1;

    // Up-run from 0 all the way through 9999 -> 0 with wrap
    goto(6);
    t0 = cyc;
    push(t0 + 1, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 9999; k++) push(t0 + 1 + 4 * k, k, 1'b0, 1'b1);
    w0 = t0 + 40001;
    push(w0, 0, 1'b1, 1'b1);
    push(w0 + 1, 0, 1'b0, 1'b1);
    press(1'b1, 1'b0);

    // Stop with the divider at 2
    goto(w0 + 1);
    push(w0 + 2, 0, 1'b0, 1'b0);
    press(1'b1, 1'b0);
    sw_mode = 1'b1;

    // Resume 20 cycles later counting down: tick 2 cycles after resume, 0 -> 9999 wraps
    r0 = w0 + 22;
    goto(r0);
    push(r0 + 1, 0, 1'b0, 1'b1);
    push(r0 + 3, 9999, 1'b1, 1'b1);
    push(r0 + 4, 9999, 1'b0, 1'b1);
    push(r0 + 7, 9998, 1'b0, 1'b1);
    press(1'b1, 1'b0);

    // Direction change between ticks takes effect at the next tick only
    goto(r0 + 8);
    sw_mode = 1'b0;
    push(r0 + 11, 9999, 1'b0, 1'b1);
    push(r0 + 15, 0, 1'b1, 1'b1);
    push(r0 + 16, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) push(r0 + 15 + 4 * k, k, 1'b0, 1'b1);

    // Clear while running is ignored
    goto(r0 + 36);
    press(1'b0, 1'b1);

    // Stop coinciding with a tick: count still steps to 6
    goto(r0 + 38);
    push(r0 + 39, 6, 1'b0, 1'b0);
    press(1'b1, 1'b0);

    // Run briefly so the divider is left at 2, then stop
    goto(r0 + 40);
    push(r0 + 41, 6, 1'b0, 1'b1);
    press(1'b1, 1'b0);
    goto(r0 + 42);
    push(r0 + 43, 6, 1'b0, 1'b0);
    press(1'b1, 1'b0);

    // Clear from stop; a run press during the clear cycle is ignored
    goto(r0 + 45);
    push(r0 + 46, 0, 1'b0, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);

    // Run after clear: first step exactly TickDiv cycles after entering run
    goto(r0 + 50);
    push(r0 + 51, 0, 1'b0, 1'b1);
    push(r0 + 55, 1, 1'b0, 1'b1);
    press(1'b1, 1'b0);
    goto(r0 + 56);
    push(r0 + 57, 1, 1'b0, 1'b0);
    press(1'b1, 1'b0);

    // Simultaneous run and clear edges in stop: clear wins
    goto(r0 + 60);
    push(r0 + 61, 0, 1'b0, 1'b0);
    press(1'b1, 1'b1);

    // Run, then asynchronous reset mid-run
    goto(r0 + 64);
    push(r0 + 65, 0, 1'b0, 1'b1);
    push(r0 + 69, 1, 1'b0, 1'b1);
    push(r0 + 73, 2, 1'b0, 1'b1);
    press(1'b1, 1'b0);
    goto(r0 + 74);
    push(r0 + 74, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_wrap", 32'(wrap), 32'd0);
    chk("async_rst_led", 32'(run_led), 32'd0);

    // Button held through reset release yields one edge
    goto(r0 + 76);
    btn_run_stop = 1'b1;
    goto(r0 + 80);
    push(r0 + 81, 0, 1'b0, 1'b1);
    push(r0 + 85, 1, 1'b0, 1'b1);
    rst = 1'b1;
    goto(r0 + 83);
    btn_run_stop = 1'b0;
    goto(r0 + 86);
    push(r0 + 87, 1, 1'b0, 1'b0);
    press(1'b1, 1'b0);

    goto(r0 + 92);
    mon_en = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event: got none, required cyc=%0d cnt=%0d wrap=%0b led=%0b",
               e.cyc, e.cnt, e.wrap, e.led);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
